// File: rtl/icache_pkg.sv
// Shared defaults, FSM state type and helper for the icache storage block.
// Optional feature macro honoured by icache_store: ICACHE_FILL_BYPASS_EN.
package icache_pkg;

    localparam int ICACHE_LINE_BITS = 512;
    localparam int ICACHE_SET_BITS  = 9;
    localparam int ICACHE_WAYS      = 2;
    localparam int ICACHE_TAG_BITS  = 20;

    // Index sweep clears valid bits; IDLE serves lookups and fills.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } icache_state_t;

    // Width of a way number; a direct-mapped cache still carries a 1-bit way.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int ICACHE_WAY_BITS = way_bits(ICACHE_WAYS);

endpackage

// File: rtl/icache_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module icache_sdp_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_BITS];

    // Storage write.
    // NOTE: the array itself has no reset so it maps onto RAM macros; clearing is the owner's job.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; the output holds between reads so results stay stable.
    // NOTE: non-blocking on both ports is what gives read-before-write on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/icache_store.sv
// Set-associative instruction-cache storage: per-way tag/valid and data RAMs,
// hit detection, round-robin victim selection, refill port and invalidation sweep.
// Optional: define ICACHE_FILL_BYPASS_EN to forward a same-cycle fill to the lookup
// response; otherwise the lookup sees the array contents before the fill.
module icache_store
    import icache_pkg::*;
#(
    parameter int  LINE_BITS = ICACHE_LINE_BITS,
    parameter int  SET_BITS  = ICACHE_SET_BITS,
    parameter int  WAYS      = ICACHE_WAYS,
    parameter int  TAG_BITS  = ICACHE_TAG_BITS,
    localparam int WAY_W     = way_bits(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    output logic                 busy_o,
    input  logic                 req_valid_i,
    input  logic [SET_BITS-1:0]  req_index_i,
    input  logic [TAG_BITS-1:0]  req_tag_i,
    output logic                 req_ready_o,
    output logic                 resp_valid_o,
    output logic                 resp_hit_o,
    output logic [WAY_W-1:0]     resp_way_o,
    output logic [LINE_BITS-1:0] resp_data_o,
    input  logic                 fill_valid_i,
    input  logic [SET_BITS-1:0]  fill_index_i,
    input  logic [TAG_BITS-1:0]  fill_tag_i,
    input  logic [LINE_BITS-1:0] fill_data_i,
    output logic                 fill_ready_o
);

    localparam int SETS = 2**SET_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
    } way_tag_t;

    icache_state_t       state;
    logic [SET_BITS-1:0] sweep_idx;
    logic                sweeping;
    logic                req_acc;
    logic                fill_acc;
    logic [TAG_BITS-1:0] req_tag_q;

    logic [WAY_W-1:0]    victim_ptr [SETS];
    logic [WAY_W-1:0]    victim_cur;
    logic [WAY_W-1:0]    victim_next;

    way_tag_t            tag_wdata;
    logic [SET_BITS-1:0] tag_waddr;
    way_tag_t            tag_rd  [WAYS];
    logic [LINE_BITS-1:0] data_rd [WAYS];

    assign sweeping     = (state == SWEEP);
    assign busy_o       = sweeping;
    assign req_ready_o  = !sweeping;
    assign fill_ready_o = !sweeping;
    assign req_acc      = req_valid_i && !sweeping;
    assign fill_acc     = fill_valid_i && !sweeping;

    assign victim_cur  = victim_ptr[fill_index_i];
    assign victim_next = (victim_cur == WAY_W'(WAYS - 1)) ? '0 : victim_cur + 1'b1;

    // The sweep owns the tag write port; fills can only arrive while idle.
    assign tag_waddr = sweeping ? sweep_idx : fill_index_i;
    assign tag_wdata = sweeping ? '0 : way_tag_t'{valid: 1'b1, tag: fill_tag_i};

    // Sweep controller: walks every index once, restarting on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        state     <= SWEEP;
                        sweep_idx <= '0;
                    end
                end
                SWEEP: begin
                    if (flush_i) begin
                        sweep_idx <= '0;
                    end else if (&sweep_idx) begin
                        state     <= IDLE;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: begin
                    state     <= SWEEP;
                    sweep_idx <= '0;
                end
            endcase
        end
    end

    // Round-robin victim per set; a flush starts every set again at way 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SETS; i++) begin
                victim_ptr[i] <= '0;
            end
        end else if (!sweeping && flush_i) begin
            for (int i = 0; i < SETS; i++) begin
                victim_ptr[i] <= '0;
            end
        end else if (fill_acc) begin
            victim_ptr[fill_index_i] <= victim_next;
        end
    end

    // Lookup bookkeeping: response strobe and the tag to compare against.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_o <= 1'b0;
            req_tag_q    <= '0;
        end else begin
            resp_valid_o <= req_acc;
            if (req_acc) begin
                req_tag_q <= req_tag_i;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic data_we;
        logic tag_we;

        assign data_we = fill_acc && (victim_cur == WAY_W'(w));
        assign tag_we  = sweeping || data_we;

        icache_sdp_ram #(
            .WIDTH      (TAG_BITS + 1),
            .DEPTH_BITS (SET_BITS)
        ) u_tag_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (tag_we),
            .wr_addr (tag_waddr),
            .wr_data (tag_wdata),
            .rd_en   (req_acc),
            .rd_addr (req_index_i),
            .rd_data (tag_rd[w])
        );

        icache_sdp_ram #(
            .WIDTH      (LINE_BITS),
            .DEPTH_BITS (SET_BITS)
        ) u_data_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (data_we),
            .wr_addr (fill_index_i),
            .wr_data (fill_data_i),
            .rd_en   (req_acc),
            .rd_addr (req_index_i),
            .rd_data (data_rd[w])
        );
    end

`ifdef ICACHE_FILL_BYPASS_EN
    logic                 byp_q;
    logic [WAY_W-1:0]     byp_way_q;
    logic [LINE_BITS-1:0] byp_data_q;

    // Capture a fill that lands on the line being looked up in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_q      <= 1'b0;
            byp_way_q  <= '0;
            byp_data_q <= '0;
        end else if (req_acc) begin
            byp_q      <= fill_acc && (fill_index_i == req_index_i) && (fill_tag_i == req_tag_i);
            byp_way_q  <= victim_cur;
            byp_data_q <= fill_data_i;
        end
    end
`endif

    // Hit detection and way mux; scanning downward lets the lowest way win.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        resp_hit_o  = 1'b0;
        resp_way_o  = '0;
        resp_data_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tag_rd[w].valid && (tag_rd[w].tag == req_tag_q)) begin
                resp_hit_o  = 1'b1;
                resp_way_o  = WAY_W'(w);
                resp_data_o = data_rd[w];
            end
        end
`ifdef ICACHE_FILL_BYPASS_EN
        if (byp_q) begin
            resp_hit_o  = 1'b1;
            resp_way_o  = byp_way_q;
            resp_data_o = byp_data_q;
        end
`endif
    end

endmodule

// File: tb/tb_icache_store.sv
// Self-checking bench for icache_store: directed scenarios plus a randomized
// lookup/fill phase, all compared against a set/way reference model.
module tb_icache_store;

    localparam int LINE  = 512;
    localparam int SETB  = 9;
    localparam int SETS  = 2**SETB;
    localparam int WAYS  = 2;
    localparam int TAGB  = 20;
    localparam int WAYW  = 1;
    localparam int SWEEP_LEN = SETS;

    logic            clk;
    logic            rst;
    logic            flush_i;
    logic            busy_o;
    logic            req_valid_i;
    logic [SETB-1:0] req_index_i;
    logic [TAGB-1:0] req_tag_i;
    logic            req_ready_o;
    logic            resp_valid_o;
    logic            resp_hit_o;
    logic [WAYW-1:0] resp_way_o;
    logic [LINE-1:0] resp_data_o;
    logic            fill_valid_i;
    logic [SETB-1:0] fill_index_i;
    logic [TAGB-1:0] fill_tag_i;
    logic [LINE-1:0] fill_data_i;
    logic            fill_ready_o;

    icache_store dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .req_valid_i  (req_valid_i),
        .req_index_i  (req_index_i),
        .req_tag_i    (req_tag_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_hit_o   (resp_hit_o),
        .resp_way_o   (resp_way_o),
        .resp_data_o  (resp_data_o),
        .fill_valid_i (fill_valid_i),
        .fill_index_i (fill_index_i),
        .fill_tag_i   (fill_tag_i),
        .fill_data_i  (fill_data_i),
        .fill_ready_o (fill_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each way of each set holds, and fills since the last flush.
    logic            m_valid [SETS][WAYS];
    logic [TAGB-1:0] m_tag   [SETS][WAYS];
    logic [LINE-1:0] m_data  [SETS][WAYS];
    int              m_fills [SETS];

    // Response the outputs must keep showing while resp_valid_o is low.
    logic            last_hit;
    int              last_way;
    logic [LINE-1:0] last_data;

    task automatic check(input string tag, input logic [LINE-1:0] observed, input logic [LINE-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
            end
            m_fills[s] = 0;
        end
    endfunction

    function automatic bit resident(input int idx, input logic [TAGB-1:0] tag);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[idx][w] && m_tag[idx][w] == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [LINE-1:0] rand_line();
        logic [LINE-1:0] v;
        for (int i = 0; i < LINE / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    // One clock of stimulus: optional lookup, fill and flush, then check the response.
    task automatic do_cycle(input bit rv, input int ridx, input logic [TAGB-1:0] rtag,
                            input bit fv, input int fidx, input logic [TAGB-1:0] ftag,
                            input logic [LINE-1:0] fdata, input bit fl, input string name);
        bit              exp_hit;
        int              exp_way;
        logic [LINE-1:0] exp_data;
        int              victim;
        exp_hit  = 1'b0;
        exp_way  = 0;
        exp_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!exp_hit && m_valid[ridx][w] && m_tag[ridx][w] == rtag) begin
                exp_hit  = 1'b1;
                exp_way  = w;
                exp_data = m_data[ridx][w];
            end
        end
        victim = m_fills[fidx] % WAYS;
`ifdef ICACHE_FILL_BYPASS_EN
        if (fv && ridx == fidx && rtag == ftag) begin
            exp_hit  = 1'b1;
            exp_way  = victim;
            exp_data = fdata;
        end
`endif
        req_valid_i  = rv;
        req_index_i  = SETB'(ridx);
        req_tag_i    = rtag;
        fill_valid_i = fv;
        fill_index_i = SETB'(fidx);
        fill_tag_i   = ftag;
        fill_data_i  = fdata;
        flush_i      = fl;
        @(posedge clk);
        #1;
        req_valid_i  = 1'b0;
        fill_valid_i = 1'b0;
        flush_i      = 1'b0;
        if (fv) begin
            m_valid[fidx][victim] = 1'b1;
            m_tag[fidx][victim]   = ftag;
            m_data[fidx][victim]  = fdata;
            m_fills[fidx]++;
        end
        if (fl) model_clear();
        if (rv) begin
            last_hit  = exp_hit;
            last_way  = exp_way;
            last_data = exp_data;
        end
        check({name, "_valid"}, resp_valid_o, rv);
        check({name, "_hit"},   resp_hit_o,   last_hit);
        check({name, "_way"},   resp_way_o,   last_way);
        check({name, "_data"},  resp_data_o,  last_data);
    endtask

    // Count cycles with busy_o high, starting from the current cycle.
    task automatic measure_busy(input string name);
        int cnt;
        cnt = 0;
        check({name, "_req_ready"},  req_ready_o,  1'b0);
        check({name, "_fill_ready"}, fill_ready_o, 1'b0);
        while (busy_o === 1'b1 && cnt < 4 * SWEEP_LEN) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check({name, "_len"},   cnt,         SWEEP_LEN);
        check({name, "_ready"}, req_ready_o, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE-1:0] d0;
        bit              rv;
        bit              fv;
        int              ridx;
        int              fidx;
        logic [TAGB-1:0] rtag;
        logic [TAGB-1:0] ftag;

        rst = 1'b0;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        req_index_i = '0;
        req_tag_i = '0;
        fill_valid_i = 1'b0;
        fill_index_i = '0;
        fill_tag_i = '0;
        fill_data_i = '0;
        last_hit = 1'b0;
        last_way = 0;
        last_data = '0;
        model_clear();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid_o, 1'b0);
        check("rst_resp_hit",   resp_hit_o,   1'b0);
        check("rst_resp_way",   resp_way_o,   '0);
        check("rst_resp_data",  resp_data_o,  '0);
        check("rst_busy",       busy_o,       1'b1);
        @(negedge clk);
        rst = 1'b1;
        measure_busy("init_sweep");

        // Freshly swept cache misses everywhere.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, $urandom_range(0, SETS - 1), TAGB'($urandom), 1'b0, 0, '0, '0, 1'b0, "cold");
        end

        // Single fill then hit in way 0.
        d0 = rand_line();
        do_cycle(1'b0, 0, '0, 1'b1, 5, 20'h00ABC, d0, 1'b0, "fill5");
        do_cycle(1'b1, 5, 20'h00ABC, 1'b0, 0, '0, '0, 1'b0, "hit5");
        check("hit5_way0_const", resp_way_o, '0);
        check("hit5_d0_const",   resp_data_o, d0);

        // Round-robin: tags 1,2,3 land in ways 0,1,0.
        for (int t = 1; t <= 3; t++) begin
            do_cycle(1'b0, 0, '0, 1'b1, 7, TAGB'(t), rand_line(), 1'b0, "fill7");
        end
        do_cycle(1'b1, 7, 20'h1, 1'b0, 0, '0, '0, 1'b0, "rr_t1");
        check("rr_t1_miss_const", resp_hit_o, 1'b0);
        do_cycle(1'b1, 7, 20'h2, 1'b0, 0, '0, '0, 1'b0, "rr_t2");
        check("rr_t2_way1_const", resp_way_o, 1'b1);
        do_cycle(1'b1, 7, 20'h3, 1'b0, 0, '0, '0, 1'b0, "rr_t3");
        check("rr_t3_way0_const", resp_way_o, 1'b0);
        do_cycle(1'b0, 0, '0, 1'b0, 0, '0, '0, 1'b0, "hold");

        // Same-cycle lookup and fill of one line.
        do_cycle(1'b1, 9, 20'h55, 1'b1, 9, 20'h55, rand_line(), 1'b0, "same9");
        do_cycle(1'b1, 9, 20'h55, 1'b0, 0, '0, '0, 1'b0, "after9");

        // Randomized traffic over a few sets and tags so hits and evictions are frequent.
        for (int i = 0; i < 300; i++) begin
            rv   = $urandom_range(0, 1) == 1;
            ridx = $urandom_range(0, 7);
            rtag = TAGB'($urandom_range(1, 4));
            fv   = $urandom_range(0, 2) == 0;
            fidx = $urandom_range(0, 7);
            ftag = TAGB'($urandom_range(1, 4));
            if (fv && resident(fidx, ftag)) fv = 1'b0;
            do_cycle(rv, ridx, rtag, fv, fidx, ftag, rand_line(), 1'b0, "rand");
        end

        // Flush from idle: the lookup in the flush cycle still sees the old contents.
        do_cycle(1'b0, 0, '0, 1'b1, 5, 20'h00ABC, d0, 1'b0, "refill5");
        do_cycle(1'b1, 5, 20'h00ABC, 1'b0, 0, '0, '0, 1'b1, "flush_lookup");
        check("flush_lookup_hit_const", resp_hit_o, 1'b1);
        measure_busy("flush_sweep");
        do_cycle(1'b1, 5, 20'h00ABC, 1'b0, 0, '0, '0, 1'b0, "post_flush5");
        check("post_flush5_miss_const", resp_hit_o, 1'b0);
        do_cycle(1'b1, 7, 20'h2, 1'b0, 0, '0, '0, 1'b0, "post_flush7");
        do_cycle(1'b1, 9, 20'h55, 1'b0, 0, '0, '0, 1'b0, "post_flush9");

        // Flush again, then re-flush at sweep index 300; lookups are refused meanwhile.
        do_cycle(1'b0, 0, '0, 1'b0, 0, '0, '0, 1'b1, "flush2");
        for (int k = 0; k < 300; k++) begin
            if (k == 10) req_valid_i = 1'b1;
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            if (k == 10) check("busy_refuse_req", resp_valid_o, 1'b0);
        end
        check("busy_at_300", busy_o, 1'b1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        measure_busy("restart_sweep");

        // Victim pointers restart at way 0 after a flush.
        do_cycle(1'b0, 0, '0, 1'b1, 5, 20'h123, rand_line(), 1'b0, "pf_fill_a");
        do_cycle(1'b1, 5, 20'h123, 1'b0, 0, '0, '0, 1'b0, "pf_hit_a");
        check("pf_way0_const", resp_way_o, 1'b0);
        do_cycle(1'b0, 0, '0, 1'b1, 5, 20'h124, rand_line(), 1'b0, "pf_fill_b");
        do_cycle(1'b1, 5, 20'h124, 1'b0, 0, '0, '0, 1'b0, "pf_hit_b");

        // Reset right after a lookup is accepted drops the response at once.
        req_valid_i = 1'b1;
        req_index_i = SETB'(5);
        req_tag_i   = 20'h123;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        check("rstmid_pending", resp_valid_o, 1'b1);
        rst = 1'b0;
        #1;
        check("rstmid_valid", resp_valid_o, 1'b0);
        check("rstmid_hit",   resp_hit_o,   1'b0);
        check("rstmid_data",  resp_data_o,  '0);
        check("rstmid_busy",  busy_o,       1'b1);
        @(posedge clk);
        #1;
        check("rstmid_valid_held", resp_valid_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        last_hit  = 1'b0;
        last_way  = 0;
        last_data = '0;
        measure_busy("rst_sweep");
        do_cycle(1'b1, 5, 20'h123, 1'b0, 0, '0, '0, 1'b0, "post_rst5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
